list_accum_ctrl: RTL

LIST_ACCUM_CTRL -- requirements
Module: list_accum_ctrl

---
 rtl/list_accum_pkg.sv | 25 ++
 rtl/list_accum_ctrl.sv | 102 ++++++++++
 2 files changed

// File: rtl/list_accum_pkg.sv
// Shared encodings for the linked-list accumulator controller and its datapath:
// ALU operation codes, FSM state encoding and the default counter width.
package list_accum_pkg;

  localparam int CNT_W_DEF = 16;
  localparam int ALU_OP_W  = 4;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_NOP   = 4'd0,
    ALU_ADD   = 4'd1,
    ALU_CLR   = 4'd2,
    ALU_LDPTR = 4'd3
  } alu_op_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_ADD     = 3'd3,
    ST_RD_NEXT = 3'd4,
    ST_LINK    = 3'd5,
    ST_DONE    = 3'd6
  } state_e;

endpackage

// File: rtl/list_accum_ctrl.sv
// Linked-list walker: sums list data words through an external datapath/BRAM.
// Define LIST_LEN_LIMIT_EN to stop at MAX_ELEMS elements and flag err.
module list_accum_ctrl
  import list_accum_pkg::*;
#(
  parameter int MAX_ELEMS = 1024,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                ram_zero,
  output logic                addr_sel,
  output logic                wr_en,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [CNT_W-1:0]    elem_count
);

  state_e           r_state;
  state_e           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             w_lim_hit;
  alu_op_e          w_op;

`ifdef LIST_LEN_LIMIT_EN
  logic r_lim;

  assign w_lim_hit = (r_cnt == CNT_W'(MAX_ELEMS));

  // Remembers whether the last LINK exit was a forced stop, so err can ride with done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                  r_lim <= 1'b0;
    else if (r_state == ST_LINK) r_lim <= !ram_zero && w_lim_hit;
  end

  assign err = (r_state == ST_DONE) && r_lim;
`else
  assign w_lim_hit = 1'b0;
  assign err       = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (start) w_next = ST_CLEAR;
      ST_CLEAR:   w_next = ST_RD_DATA;
      ST_RD_DATA: w_next = ST_ADD;
      ST_ADD:     w_next = ST_RD_NEXT;
      ST_RD_NEXT: w_next = ST_LINK;
      ST_LINK:    w_next = (ram_zero || w_lim_hit) ? ST_DONE : ST_RD_DATA;
      ST_DONE:    w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    addr_sel = 1'b0;
    wr_en    = 1'b0;
    w_op     = ALU_NOP;
    case (r_state)
      ST_CLEAR: begin
        wr_en = 1'b1;
        w_op  = ALU_CLR;
      end
      ST_ADD: begin
        wr_en = 1'b1;
        w_op  = ALU_ADD;
      end
      ST_RD_NEXT: addr_sel = 1'b1;
      ST_LINK: begin
        addr_sel = 1'b1;
        if (!ram_zero && !w_lim_hit) begin
          wr_en = 1'b1;
          w_op  = ALU_LDPTR;
        end
      end
      default: ;
    endcase
  end

  assign alu_op = w_op;
  assign busy   = (r_state != ST_IDLE);
  assign done   = (r_state == ST_DONE);

  // Count saturates rather than wrapping so a huge list never reports a small total.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                   r_cnt <= '0;
    else if (r_state == ST_CLEAR) r_cnt <= '0;
    else if (r_state == ST_ADD && !(&r_cnt)) r_cnt <= r_cnt + 1'b1;
  end

  assign elem_count = r_cnt;

endmodule
